// File: rtl/multicycle_core.sv
// ============================================================================
// Module   : multicycle_core
// Purpose  : Parametrised multicycle MIPS-subset core. A five-state FSM
//            (FETCH, DECODE, EXEC, MEM, WB) plus an absorbing HALT state
//            drives external synchronous instruction and data memories.
//            Supported: add, sub, and, or, slt, addi, lw, sw, beq, j.
//            Any other encoding halts the core until reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_W      register / ALU / data-memory word width
//   PC_W        program counter width (word-addressed memories)
//   REG_ADDR_W  register index width (2^REG_ADDR_W registers, r0 reads 0)
// Ports:
//   iCLK, iRST_N     clock (rising edge), asynchronous active-low reset
//   iSTEP            advance enable (only with CORE_STEP_EN)
//   oIADDR/iIDATA    instruction address / word (word valid one cycle later)
//   oDADDR/oDWDATA   data address (ALU result reg) / store data (rt value)
//   oDWE/iDRDATA     data write strobe / load data (valid one cycle later)
//   iDBG_RA/oDBG_RD  debug register select / combinational register read
//   oPC, oSTATE      current PC / FSM state encoding
//   oRETIRE, oHALT   instruction-complete pulse / halted flag
// Configuration macro:
//   CORE_STEP_EN     when defined, all state advances only while iSTEP=1
// ============================================================================
`default_nettype none

module multicycle_core #(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iSTEP,
  output logic [PC_W-1:0]       oIADDR,
  input  logic [31:0]           iIDATA,
  output logic [DATA_W-1:0]     oDADDR,
  output logic [DATA_W-1:0]     oDWDATA,
  output logic                  oDWE,
  input  logic [DATA_W-1:0]     iDRDATA,
  input  logic [REG_ADDR_W-1:0] iDBG_RA,
  output logic [DATA_W-1:0]     oDBG_RD,
  output logic [PC_W-1:0]       oPC,
  output logic [2:0]            oSTATE,
  output logic                  oRETIRE,
  output logic                  oHALT
);

  localparam int C_NREGS = 1 << REG_ADDR_W;

  // FSM state encoding (visible on oSTATE)
  localparam logic [2:0] C_FETCH  = 3'd0;
  localparam logic [2:0] C_DECODE = 3'd1;
  localparam logic [2:0] C_EXEC   = 3'd2;
  localparam logic [2:0] C_MEM    = 3'd3;
  localparam logic [2:0] C_WB     = 3'd4;
  localparam logic [2:0] C_HALT   = 3'd7;

  // Opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_J     = 6'h02;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] C_FN_ADD = 6'h20;
  localparam logic [5:0] C_FN_SUB = 6'h22;
  localparam logic [5:0] C_FN_AND = 6'h24;
  localparam logic [5:0] C_FN_OR  = 6'h25;
  localparam logic [5:0] C_FN_SLT = 6'h2A;

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_alu_out;

  // Global advance qualifier: every register update and every strobe is
  // gated by it, so holding iSTEP low freezes the whole core.
  logic w_adv;
`ifdef CORE_STEP_EN
  assign w_adv = iSTEP;
`else
  assign w_adv = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  // Fields of the incoming word, needed during DECODE before IR is loaded.
  logic [5:0]            w_op_in;
  logic [5:0]            w_fn_in;
  logic [REG_ADDR_W-1:0] w_rs_in;
  logic [REG_ADDR_W-1:0] w_rt_in;

  assign w_op_in = iIDATA[31:26];
  assign w_fn_in = iIDATA[5:0];
  assign w_rs_in = iIDATA[21 +: REG_ADDR_W];
  assign w_rt_in = iIDATA[16 +: REG_ADDR_W];

  // Fields of the latched instruction, used from EXEC onwards.
  logic [5:0]            w_op;
  logic [5:0]            w_fn;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [31:0]           w_imm_ext;
  logic [DATA_W-1:0]     w_imm;

  assign w_op      = r_ir[31:26];
  assign w_fn      = r_ir[5:0];
  assign w_rt      = r_ir[16 +: REG_ADDR_W];
  assign w_rd      = r_ir[11 +: REG_ADDR_W];
  assign w_imm_ext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_imm     = w_imm_ext[DATA_W-1:0];

  logic w_is_rtype;
  logic w_is_addi;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_j;

  assign w_is_rtype = (w_op == C_OP_RTYPE);
  assign w_is_addi  = (w_op == C_OP_ADDI);
  assign w_is_lw    = (w_op == C_OP_LW);
  assign w_is_sw    = (w_op == C_OP_SW);
  assign w_is_beq   = (w_op == C_OP_BEQ);
  assign w_is_j     = (w_op == C_OP_J);

  // Legality is judged on the incoming word so DECODE can branch to HALT.
  logic w_dec_legal;
  always_comb begin
    w_dec_legal = 1'b0;
    case (w_op_in)
      C_OP_RTYPE: begin
        case (w_fn_in)
          C_FN_ADD, C_FN_SUB, C_FN_AND, C_FN_OR, C_FN_SLT: w_dec_legal = 1'b1;
          default:                                         w_dec_legal = 1'b0;
        endcase
      end
      C_OP_ADDI, C_OP_LW, C_OP_SW, C_OP_BEQ, C_OP_J: w_dec_legal = 1'b1;
      default:                                       w_dec_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file: r0 has no storage and is hard-wired to zero, which also
  // makes writes to r0 vanish without an explicit check.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]     w_rf [C_NREGS];
  logic                  w_rf_we;
  logic [REG_ADDR_W-1:0] w_wb_addr;
  logic [DATA_W-1:0]     w_wb_data;

  assign w_rf_we   = w_adv && (r_state == C_WB);
  assign w_wb_addr = w_is_rtype ? w_rd : w_rt;
  assign w_wb_data = w_is_lw ? iDRDATA : r_alu_out;

  generate
    for (genvar gi = 0; gi < C_NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_rf[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge iCLK or negedge iRST_N) begin
          if (!iRST_N) begin
            r_q <= '0;
          end else if (w_rf_we && (w_wb_addr == REG_ADDR_W'(gi))) begin
            r_q <= w_wb_data;
          end
        end
        assign w_rf[gi] = r_q;
      end
    end
  endgenerate

  logic [DATA_W-1:0] w_rf_rs;
  logic [DATA_W-1:0] w_rf_rt;

  assign w_rf_rs = w_rf[w_rs_in];
  assign w_rf_rt = w_rf[w_rt_in];

  // --------------------------------------------------------------------------
  // ALU: operates on the latched A/B operands and the latched instruction.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_alu_res;
  always_comb begin
    w_alu_res = '0;
    if (w_is_rtype) begin
      case (w_fn)
        C_FN_ADD: w_alu_res = r_a + r_b;
        C_FN_SUB: w_alu_res = r_a - r_b;
        C_FN_AND: w_alu_res = r_a & r_b;
        C_FN_OR:  w_alu_res = r_a | r_b;
        C_FN_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
        default:  w_alu_res = '0;
      endcase
    end else begin
      // addi, lw and sw all compute A + imm
      w_alu_res = r_a + w_imm;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= C_FETCH;
    end else if (w_adv) begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_FETCH:  w_state_nxt = C_DECODE;
      C_DECODE: w_state_nxt = w_dec_legal ? C_EXEC : C_HALT;
      C_EXEC: begin
        if (w_is_rtype || w_is_addi) begin
          w_state_nxt = C_WB;
        end else if (w_is_lw || w_is_sw) begin
          w_state_nxt = C_MEM;
        end else begin
          w_state_nxt = C_FETCH;              // beq and j finish here
        end
      end
      C_MEM:    w_state_nxt = w_is_lw ? C_WB : C_FETCH;
      C_WB:     w_state_nxt = C_FETCH;
      C_HALT:   w_state_nxt = C_HALT;
      default:  w_state_nxt = C_HALT;         // unused encodings are treated as fatal
    endcase
  end

  // FSM: output decode from registered state and IR only, so no path
  // exists from the memory data inputs to these strobes.
  logic w_dwe;
  logic w_retire;
  logic w_halt;
  always_comb begin
    w_dwe    = 1'b0;
    w_retire = 1'b0;
    w_halt   = 1'b0;
    case (r_state)
      C_EXEC: w_retire = w_is_beq | w_is_j;
      C_MEM: begin
        w_dwe    = w_is_sw;
        w_retire = w_is_sw;
      end
      C_WB:   w_retire = 1'b1;
      C_HALT: w_halt   = 1'b1;
      default: begin
        w_dwe    = 1'b0;
        w_retire = 1'b0;
        w_halt   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
    end else if (w_adv) begin
      case (r_state)
        C_FETCH: r_pc <= r_pc + PC_W'(1);
        C_DECODE: begin
          r_ir <= iIDATA;
          r_a  <= w_rf_rs;
          r_b  <= w_rf_rt;
        end
        C_EXEC: begin
          r_alu_out <= w_alu_res;
          // PC already holds old PC+1, so the offset is relative to that.
          if (w_is_beq && (r_a == r_b)) begin
            r_pc <= r_pc + w_imm_ext[PC_W-1:0];
          end
          if (w_is_j) begin
            r_pc <= r_ir[PC_W-1:0];
          end
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign oIADDR  = r_pc;
  assign oPC     = r_pc;
  assign oDADDR  = r_alu_out;
  assign oDWDATA = r_b;
  assign oSTATE  = r_state;
  assign oDWE    = w_dwe & w_adv;
  assign oRETIRE = w_retire & w_adv;
  assign oHALT   = w_halt;
  assign oDBG_RD = w_rf[iDBG_RA];

  // Instruction bits that some parameterisations never look at (rs field of
  // IR, high register-index bits, jump-target bits above PC_W) and iSTEP in
  // the free-running build are collected here on purpose.
  logic w_unused_bits;
  assign w_unused_bits = ^{iSTEP, r_ir, w_imm_ext};

endmodule

`default_nettype wire
